demux_4_buf: RTL and testbench
==============================

DEMUX_4_BUF -- requirements
Module: demux_4_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: width of each data word.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port sel, input, 4: one-hot destination select for the word on data_i; bit k selects output k.
REQ-005 SHALL have port data_i, input, DATA_WIDTH: upstream data word.
REQ-006 SHALL have port valid_i, input, 1: upstream word and sel are valid.
REQ-007 SHALL have port ready_o, output, 1: the block can accept a word this cycle.
REQ-008 SHALL have ports data_o_0 .. data_o_3, output, DATA_WIDTH each: per-destination data.
REQ-009 SHALL have port valid_o, output, 4: per-destination valid; bit k qualifies data_o_k.
REQ-010 SHALL have port ready_i, input, 4: per-destination ready; bit k is from destination k.
REQ-011 SHALL have port drop_o, output, 1: one-cycle pulse when a word with an illegal sel was discarded.
REQ-012 SHALL have port drop_cnt_o, output, 8: saturating count of discarded words.

Function
REQ-013 SHALL hold accepted words in a 2-entry FIFO; each entry stores data_i and sel.
REQ-014 SHALL accept a word on a rising edge when valid_i=1 and ready_o=1.
REQ-015 SHALL drive ready_o=1 when the FIFO occupancy is below 2, from registered state only, with no combinational path from ready_i or valid_i.
REQ-016 SHALL store an accepted word only when sel has exactly one bit set.
REQ-017 SHALL discard an accepted word whose sel is 4'b0000 or has two or more bits set.
  - No FIFO write for that word.
  - drop_o=1 in the following cycle.
  - drop_cnt_o increments by 1, saturating at 255.
REQ-018 SHALL, when the FIFO is non-empty, present the head entry:
  - valid_o = head sel.
  - data_o_k = head data for the selected k.
  - all unselected data_o_k = 0.
REQ-019 SHALL, when the FIFO is empty, drive valid_o=4'b0000 and all data_o_k=0.
REQ-020 SHALL pop the head entry on a rising edge when (valid_o & ready_i) != 0; ready_i bits for unselected destinations SHALL have no effect.
REQ-021 SHALL give latency of exactly one cycle: a word accepted on edge N appears on valid_o/data_o after edge N if the FIFO was empty, otherwise when it reaches the head.
REQ-022 SHALL preserve acceptance order across all destinations; a stalled head blocks later words even if those target ready destinations (in-order, head-of-line blocking).
REQ-023 SHALL, on simultaneous push and pop, leave occupancy unchanged and advance the head; with occupancy 1 this sustains one word per cycle.
REQ-024 SHALL, on simultaneous pop and illegal-sel accept, perform the pop and the drop independently.
REQ-025 SHALL keep valid_o and data_o_k stable while the head is not popped.
REQ-026 SHALL implement FIFO pointers as 1-bit wrap-around indices and occupancy as a 2-bit count in the range 0..2.

Reset
REQ-027 SHALL, while rst=1, asynchronously force:
  - FIFO occupancy = 0, both pointers = 0.
  - ready_o = 0.
  - valid_o = 4'b0000, data_o_0..3 = 0.
  - drop_o = 0, drop_cnt_o = 0.
REQ-028 SHALL drive ready_o=1 from the first rising edge after rst deasserts.
REQ-029 SHALL, on reset asserted mid-transfer, lose all buffered words, and no valid_o bit SHALL remain set.

Verification
REQ-030 SHALL cover single transfer: FIFO empty, sel=4'b0100, data_i=4'hA, ready_i=4'b1111 -> next cycle valid_o=4'b0100, data_o_2=4'hA, other outputs 0; popped on that edge.
REQ-031 SHALL cover backpressure: ready_i=0, push 4'h1 to output 0 and 4'h2 to output 3 -> ready_o=0 after two accepts; raise ready_i[0] -> 4'h1 popped and ready_o=1; then valid_o=4'b1000, data_o_3=4'h2.
REQ-032 SHALL cover streaming: 16 back-to-back words with rotating one-hot sel, all ready_i=1 -> one word per cycle, order preserved, ready_o never 0.
REQ-033 SHALL cover illegal sel: sel=4'b0011 accepted -> drop_o one-cycle pulse, drop_cnt_o=1, valid_o unchanged; 300 illegal words -> drop_cnt_o=255.
REQ-034 SHALL cover head-of-line blocking: head sel=4'b0001 with ready_i[0]=0, next word sel=4'b0010 with ready_i[1]=1 -> valid_o stays 4'b0001 and nothing is popped.
REQ-035 SHALL cover mid-operation reset: FIFO holds 2 words, rst pulsed between edges -> valid_o=0, ready_o=0, drop_cnt_o=0 immediately; ready_o=1 after the first edge post-release.

Source files
------------

// File: rtl/demux_4_buf_if.sv
// Handshake bundle for the 4-way buffered demux.
// slave = demux side, master = upstream source and downstream sinks.
interface demux_4_buf_if #(
  parameter int DATA_WIDTH = 4
);
  logic [3:0]            sel;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] data_o_0;
  logic [DATA_WIDTH-1:0] data_o_1;
  logic [DATA_WIDTH-1:0] data_o_2;
  logic [DATA_WIDTH-1:0] data_o_3;
  logic [3:0]            valid_o;
  logic [3:0]            ready_i;
  logic                  drop_o;
  logic [7:0]            drop_cnt_o;

  modport slave (
    input  sel, data_i, valid_i, ready_i,
    output ready_o, data_o_0, data_o_1, data_o_2, data_o_3,
    output valid_o, drop_o, drop_cnt_o
  );

  modport master (
    output sel, data_i, valid_i, ready_i,
    input  ready_o, data_o_0, data_o_1, data_o_2, data_o_3,
    input  valid_o, drop_o, drop_cnt_o
  );
endinterface

// File: rtl/demux_4_buf.sv
// 1-to-4 demux behind a 2-entry in-order FIFO.
// Words with a non-one-hot select are dropped and counted.
module demux_4_buf #(
  parameter int DATA_WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  demux_4_buf_if.slave   bus
);

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t       data_q [2];
  logic [3:0]  sel_q  [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        rdy_q;
  logic        drop_q, drop_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  logic        legal;
  logic        accept;
  logic        push;
  logic        pop;
  logic [3:0]  head_sel;
  word_t       head_data;

  assign legal = (bus.sel != 4'b0000) &&
                 ((bus.sel & (bus.sel - 4'd1)) == 4'b0000);

  // rdy_q keeps ready_o low through reset and the release cycle
  assign bus.ready_o = rdy_q && (cnt_q != 2'd2);
  assign accept      = bus.valid_i && bus.ready_o;
  assign push        = accept && legal;
  assign drop_d      = accept && !legal;

  assign head_sel  = (cnt_q == 2'd0) ? 4'b0000 : sel_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign pop       = |(head_sel & bus.ready_i);

  assign bus.valid_o    = head_sel;
  assign bus.data_o_0   = head_sel[0] ? head_data : '0;
  assign bus.data_o_1   = head_sel[1] ? head_data : '0;
  assign bus.data_o_2   = head_sel[2] ? head_data : '0;
  assign bus.data_o_3   = head_sel[3] ? head_data : '0;
  assign bus.drop_o     = drop_q;
  assign bus.drop_cnt_o = drop_cnt_q;

  always_comb begin
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    drop_cnt_d = drop_cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (drop_d && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        sel_q[i]  <= 4'b0000;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      rdy_q      <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= bus.data_i;
        sel_q[wr_ptr_q]  <= bus.sel;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rdy_q      <= 1'b1;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_demux_4_buf.sv
// Bench for demux_4_buf: queue scoreboard checked every cycle,
// a vector table of single transfers and directed corner sequences.
module tb_demux_4_buf;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  int   cyc;

  demux_4_buf_if #(.DATA_WIDTH(4)) bus ();

  demux_4_buf #(.DATA_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] data;
  } ent_t;

  ent_t       mq[$];
  logic       m_ready = 1'b0;
  logic       m_drop  = 1'b0;
  logic [7:0] m_cnt   = 8'd0;

  function automatic bit one_hot(input logic [3:0] s);
    return $countones(s) == 1;
  endfunction

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [3:0] dout(input int k);
    case (k)
      0:       return bus.data_o_0;
      1:       return bus.data_o_1;
      2:       return bus.data_o_2;
      default: return bus.data_o_3;
    endcase
  endfunction

  // Reference: expected words enter on accept and leave on pop.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ready <= 1'b0;
      m_drop  <= 1'b0;
      m_cnt   <= 8'd0;
    end else begin
      m_drop <= bus.valid_i && m_ready && (mq.size() < 2) &&
                !one_hot(bus.sel);
      if (bus.valid_i && m_ready && (mq.size() < 2) &&
          !one_hot(bus.sel) && (m_cnt != 8'hFF))
        m_cnt <= m_cnt + 8'd1;
      m_ready <= 1'b1;
      if (bus.valid_i && m_ready && (mq.size() < 2) &&
          one_hot(bus.sel)) begin
        if ((mq.size() > 0) && ((mq[0].sel & bus.ready_i) != 0))
          void'(mq.pop_front());
        mq.push_back('{sel: bus.sel, data: bus.data_i});
      end else if ((mq.size() > 0) &&
                   ((mq[0].sel & bus.ready_i) != 0)) begin
        void'(mq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] ev;
    logic [3:0] ed;
    ev = (mq.size() > 0) ? mq[0].sel  : 4'b0000;
    ed = (mq.size() > 0) ? mq[0].data : 4'h0;
    chk("sb_valid_o", bus.valid_o, ev);
    chk("sb_data_o_0", bus.data_o_0, ev[0] ? ed : 4'h0);
    chk("sb_data_o_1", bus.data_o_1, ev[1] ? ed : 4'h0);
    chk("sb_data_o_2", bus.data_o_2, ev[2] ? ed : 4'h0);
    chk("sb_data_o_3", bus.data_o_3, ev[3] ? ed : 4'h0);
    chk("sb_ready_o", bus.ready_o, m_ready && (mq.size() < 2));
    chk("sb_drop_o", bus.drop_o, m_drop);
    chk("sb_drop_cnt_o", bus.drop_cnt_o, m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid_i = 1'b0;
    bus.sel     = 4'b0000;
    bus.data_i  = 4'h0;
  endtask

  task automatic send(input logic [3:0] s, input logic [3:0] d);
    bit acc;
    acc = 1'b0;
    bus.valid_i = 1'b1;
    bus.sel     = s;
    bus.data_i  = d;
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = bus.ready_o;
      tick();
    end
    chk("send_accept_timeout", acc, 1'b1);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [3:0] sel;
    logic [3:0] data;
    logic [3:0] exp_valid;
    logic [3:0] exp_data;
    logic       exp_drop;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{4'b0100, 4'hA, 4'b0100, 4'hA, 1'b0};
    vt[1] = '{4'b0001, 4'h3, 4'b0001, 4'h3, 1'b0};
    vt[2] = '{4'b0010, 4'h7, 4'b0010, 4'h7, 1'b0};
    vt[3] = '{4'b1000, 4'hF, 4'b1000, 4'hF, 1'b0};
    vt[4] = '{4'b0000, 4'h5, 4'b0000, 4'h0, 1'b1};
    vt[5] = '{4'b0110, 4'h9, 4'b0000, 4'h0, 1'b1};
    vt[6] = '{4'b1111, 4'hC, 4'b0000, 4'h0, 1'b1};

    n_cmp       = 0;
    n_fail      = 0;
    cyc         = 0;
    rst         = 1'b0;
    bus.ready_i = 4'b0000;
    idle();

    #1 rst = 1'b1;
    #1;
    chk("rst_valid_o", bus.valid_o, 4'b0000);
    chk("rst_ready_o", bus.ready_o, 1'b0);
    chk("rst_drop_o", bus.drop_o, 1'b0);
    chk("rst_drop_cnt_o", bus.drop_cnt_o, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rst_held_ready_o", bus.ready_o, 1'b0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready_o", bus.ready_o, 1'b1);

    // single transfers from an empty FIFO
    bus.ready_i = 4'b1111;
    foreach (vt[i]) begin
      send(vt[i].sel, vt[i].data);
      idle();
      chk("vec_valid_o", bus.valid_o, vt[i].exp_valid);
      for (int k = 0; k < 4; k++)
        chk("vec_data_o", dout(k),
            vt[i].exp_valid[k] ? vt[i].exp_data : 4'h0);
      chk("vec_drop_o", bus.drop_o, vt[i].exp_drop);
      tick();
      chk("vec_popped", bus.valid_o, 4'b0000);
    end

    // streaming, one word per cycle
    begin
      int c0;
      c0 = cyc;
      for (int i = 0; i < 16; i++) begin
        chk("stream_ready_o", bus.ready_o, 1'b1);
        send(4'b0001 << (i % 4), 4'(i));
      end
      idle();
      chk("stream_cycles", cyc - c0, 16);
      tick();
      tick();
    end

    // backpressure fills the FIFO
    bus.ready_i = 4'b0000;
    send(4'b0001, 4'h1);
    send(4'b1000, 4'h2);
    idle();
    chk("bp_full_ready_o", bus.ready_o, 1'b0);
    chk("bp_head_valid_o", bus.valid_o, 4'b0001);
    chk("bp_head_data_o_0", bus.data_o_0, 4'h1);
    bus.ready_i = 4'b0001;
    tick();
    chk("bp_pop_ready_o", bus.ready_o, 1'b1);
    chk("bp_next_valid_o", bus.valid_o, 4'b1000);
    chk("bp_next_data_o_3", bus.data_o_3, 4'h2);
    bus.ready_i = 4'b1111;
    tick();
    chk("bp_drained", bus.valid_o, 4'b0000);

    // head-of-line blocking
    bus.ready_i = 4'b0010;
    send(4'b0001, 4'h3);
    send(4'b0010, 4'h4);
    idle();
    tick();
    tick();
    tick();
    chk("hol_valid_o", bus.valid_o, 4'b0001);
    chk("hol_data_o_0", bus.data_o_0, 4'h3);
    chk("hol_data_o_1", bus.data_o_1, 4'h0);
    chk("hol_ready_o", bus.ready_o, 1'b0);
    bus.ready_i = 4'b1111;
    tick();
    tick();
    chk("hol_drained", bus.valid_o, 4'b0000);

    // illegal select with a stalled word in the FIFO
    pulse_reset();
    bus.ready_i = 4'b0000;
    send(4'b0010, 4'h5);
    send(4'b0011, 4'hE);
    idle();
    chk("drop_pulse", bus.drop_o, 1'b1);
    chk("drop_cnt_one", bus.drop_cnt_o, 8'd1);
    chk("drop_valid_kept", bus.valid_o, 4'b0010);
    chk("drop_data_kept", bus.data_o_1, 4'h5);
    tick();
    chk("drop_pulse_end", bus.drop_o, 1'b0);
    for (int i = 0; i < 300; i++)
      send((i % 2 == 0) ? 4'b0000 : 4'b1100, 4'(i));
    idle();
    tick();
    chk("drop_cnt_sat", bus.drop_cnt_o, 8'd255);
    bus.ready_i = 4'b1111;
    tick();

    // reset with two words buffered
    bus.ready_i = 4'b0000;
    send(4'b0100, 4'h6);
    send(4'b0001, 4'h7);
    idle();
    chk("mr_full_valid_o", bus.valid_o, 4'b0100);
    #1 rst = 1'b1;
    #1;
    chk("mr_valid_o", bus.valid_o, 4'b0000);
    chk("mr_ready_o", bus.ready_o, 1'b0);
    chk("mr_drop_cnt_o", bus.drop_cnt_o, 8'd0);
    chk("mr_data_o_2", bus.data_o_2, 4'h0);
    #1 rst = 1'b0;
    tick();
    chk("mr_rel_ready_o", bus.ready_o, 1'b1);
    chk("mr_rel_valid_o", bus.valid_o, 4'b0000);
    bus.ready_i = 4'b1111;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
